// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer (IF/ID/EX/MEM/WB/HALT); strobes are combinational from state, opcode, bcond, mem_ready.
// Memory stalls hold IF/MEM until mem_ready; a watchdog halts after MAX_MEM_WAIT idle cycles (0 disables it).
module multicycle_control_fsm #(
  parameter int MAX_MEM_WAIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       mem_timeout
);

  localparam int CNT_W = (MAX_MEM_WAIT > 0) ? $clog2(MAX_MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_MEM_WAIT);
  localparam bit WDOG_EN = (MAX_MEM_WAIT > 0);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             wait_hit;
  logic             timeout_fire;
  logic             is_load;
  logic             needs_ex;

  assign is_load  = (opcode == OP_LOAD);
  assign wait_hit = WDOG_EN && (wait_cnt_q == WAIT_LIMIT) && !mem_ready;

  always_comb begin
    case (opcode)
      OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR: needs_ex = 1'b1;
      default:                    needs_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 2'd0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end else if (wait_hit) begin
          timeout_fire = 1'b1;
          state_d      = S_HALT;
        end
      end
      S_ID: begin
        // ALUOut <= PC + imm, ready for branch/jal targets in EX
        alu_src_b = 1'b1;
        if (opcode == OP_ECALL && halt_req) begin
          state_d = S_HALT;
        end else if (needs_ex) begin
          state_d = S_EX;
        end else begin
          pc_write = 1'b1;
          state_d  = S_IF;
        end
      end
      S_EX: begin
        state_d = S_IF;
        case (opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
            state_d   = S_WB;
          end
          OP_ARITH_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            alu_op    = 2'd1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
            pc_write  = 1'b1;
            pc_source = bcond ? 2'd1 : 2'd0;
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_source = 2'd1;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_source = 2'd2;
          end
          default: pc_write = 1'b1;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = !is_load;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        end else if (wait_hit) begin
          timeout_fire = 1'b1;
          state_d      = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? 2'd1 : 2'd0;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Reset held low silences every strobe, including the IF read
    if (!reset) begin
      pc_write  = 1'b0;
      pc_source = 2'd0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IF;
      wait_cnt_q  <= '0;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      halted      <= (state_d == S_HALT);
      mem_timeout <= mem_timeout | timeout_fire;
      if ((state_q == S_IF || state_q == S_MEM) && state_d == state_q && !mem_ready)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      else
        wait_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: instruction-level reference model against observed strobe statistics.
module tb_multicycle_control_fsm;

  localparam int MAXW = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_EC   = 7'b1110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       bcond = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, alu_src_b, halted, mem_timeout;
  logic [1:0] pc_source, wb_sel, alu_op;
  logic [13:0] ctrl;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] pcw;
    logic [1:0] src;
    logic [3:0] rw;
    logic [1:0] wb;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [7:0] io;
    logic [3:0] ir;
    logic [3:0] id_alu;
    logic [3:0] ex_alu;
    logic       clash;
    logic       hlt;
    logic       tmo;
    logic       hung;
  } stat_t;

  multicycle_control_fsm #(.MAX_MEM_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .halted(halted), .mem_timeout(mem_timeout)
  );

  assign ctrl = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                 reg_write, wb_sel, alu_src_a, alu_src_b, alu_op};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // Expected per-instruction statistics from phase lengths: fetch, decode, execute, memory, write-back
  function automatic stat_t model(input logic [6:0] op, input logic bc, input logic hr,
                                  input int wif, input int wmem);
    stat_t s;
    s = '0;
    if (wif > MAXW) begin
      s.cycles = 8'(MAXW + 1);
      s.rd     = 8'(MAXW + 1);
      s.hlt    = 1'b1;
      s.tmo    = 1'b1;
      return s;
    end
    s.cycles = 8'(wif + 2);
    s.rd     = 8'(wif + 1);
    s.ir     = 4'd1;
    s.id_alu = 4'b0100;
    case (op)
      OP_EC: if (hr) s.hlt = 1'b1; else s.pcw = 4'd1;
      OP_R: begin s.cycles += 8'd2; s.pcw = 4'd1; s.rw = 4'd1; s.ex_alu = 4'b1001; end
      OP_I: begin s.cycles += 8'd2; s.pcw = 4'd1; s.rw = 4'd1; s.ex_alu = 4'b1101; end
      OP_LD, OP_ST: begin
        s.cycles += 8'd1;
        s.ex_alu = 4'b1100;
        if (wmem > MAXW) begin
          s.cycles += 8'(MAXW + 1);
          s.io = 8'(MAXW + 1);
          if (op == OP_LD) s.rd += 8'(MAXW + 1); else s.wr = 8'(MAXW + 1);
          s.hlt = 1'b1;
          s.tmo = 1'b1;
        end else begin
          s.io  = 8'(wmem + 1);
          s.pcw = 4'd1;
          if (op == OP_LD) begin
            s.cycles += 8'(wmem + 2);
            s.rd += 8'(wmem + 1);
            s.rw = 4'd1;
            s.wb = 2'd1;
          end else begin
            s.cycles += 8'(wmem + 1);
            s.wr = 8'(wmem + 1);
          end
        end
      end
      OP_BR:   begin s.cycles += 8'd1; s.pcw = 4'd1; s.src = {1'b0, bc}; s.ex_alu = 4'b1010; end
      OP_JAL:  begin s.cycles += 8'd1; s.pcw = 4'd1; s.src = 2'd1; s.rw = 4'd1; s.wb = 2'd2; end
      OP_JALR: begin s.cycles += 8'd1; s.pcw = 4'd1; s.src = 2'd2; s.rw = 4'd1; s.wb = 2'd2;
                     s.ex_alu = 4'b1100; end
      default: s.pcw = 4'd1;
    endcase
    return s;
  endfunction

  // Drives one instruction: memory answers on request cycle wif+1 (fetch) and wmem+1 (data)
  task automatic run_instr(input logic [6:0] op, input logic bc, input logic hr,
                           input int wif, input int wmem, output stat_t s);
    int req_cnt, ir_at, cyc;
    logic seen_ir, done;
    s = '0;
    req_cnt = 0;
    ir_at = -10;
    seen_ir = 1'b0;
    done = 1'b0;
    opcode = op;
    bcond = bc;
    halt_req = hr;
    for (int n = 0; n < 64; n++) begin
      mem_ready = 1'b0;
      #1;
      if (halted) begin
        s.hlt = 1'b1;
        s.tmo = mem_timeout;
        done = 1'b1;
        break;
      end
      if (mem_read | mem_write) begin
        mem_ready = (req_cnt == (seen_ir ? wmem : wif));
        req_cnt++;
        if (mem_ready) req_cnt = 0;
      end
      #1;
      cyc = int'(s.cycles);
      s.cycles++;
      if (mem_read) s.rd++;
      if (mem_write) s.wr++;
      if (i_or_d) s.io++;
      if (ir_write) begin s.ir++; seen_ir = 1'b1; ir_at = cyc; end
      if (cyc == ir_at + 1) s.id_alu = {alu_src_a, alu_src_b, alu_op};
      if (cyc == ir_at + 2) s.ex_alu = {alu_src_a, alu_src_b, alu_op};
      if (reg_write) begin s.rw++; s.wb = wb_sel; end
      if (pc_write & ir_write) s.clash = 1'b1;
      if (pc_write) begin s.pcw++; s.src = pc_source; done = 1'b1; end
      @(negedge clk);
      if (done) break;
    end
    mem_ready = 1'b0;
    if (!done) s.hung = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++; if (ctrl !== 14'd0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", ctrl); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({mem_read, i_or_d} !== 2'b10) begin
      bad++; $display("FAIL first_fetch: got rd/iord=%b want 10", {mem_read, i_or_d});
    end
  endtask

  task automatic test_add();
    stat_t o, e;
    run_instr(OP_R, 1'b0, 1'b0, 0, 0, o);
    e = model(OP_R, 1'b0, 1'b0, 0, 0);
    total++; if (o !== e) begin bad++; $display("FAIL add: got %h want %h", o, e); end
    total++; if (o.cycles !== 8'd4) begin bad++; $display("FAIL add_cycles: got %0d want 4", o.cycles); end
  endtask

  task automatic test_load();
    stat_t o, e;
    run_instr(OP_LD, 1'b0, 1'b0, 2, 2, o);
    e = model(OP_LD, 1'b0, 1'b0, 2, 2);
    total++; if (o !== e) begin bad++; $display("FAIL lw: got %h want %h", o, e); end
    total++;
    if (o.cycles !== 8'd9 || o.wb !== 2'd1) begin
      bad++; $display("FAIL lw_cycles: got %0d/%0d want 9/1", o.cycles, o.wb);
    end
  endtask

  task automatic test_branch();
    stat_t o, e;
    for (int b = 1; b >= 0; b--) begin
      run_instr(OP_BR, b[0], 1'b0, 0, 0, o);
      e = model(OP_BR, b[0], 1'b0, 0, 0);
      total++; if (o !== e) begin bad++; $display("FAIL beq_%0d: got %h want %h", b, o, e); end
      total++;
      if (o.cycles !== 8'd3 || o.rw !== 4'd0) begin
        bad++; $display("FAIL beq_len_%0d: got %0d/%0d want 3/0", b, o.cycles, o.rw);
      end
    end
  endtask

  task automatic test_jumps();
    stat_t o, e;
    run_instr(OP_JAL, 1'b0, 1'b0, 1, 0, o);
    e = model(OP_JAL, 1'b0, 1'b0, 1, 0);
    total++; if (o !== e) begin bad++; $display("FAIL jal: got %h want %h", o, e); end
    run_instr(OP_JALR, 1'b0, 1'b0, 0, 0, o);
    e = model(OP_JALR, 1'b0, 1'b0, 0, 0);
    total++; if (o !== e) begin bad++; $display("FAIL jalr: got %h want %h", o, e); end
    run_instr(OP_LUI, 1'b0, 1'b0, 0, 0, o);
    e = model(OP_LUI, 1'b0, 1'b0, 0, 0);
    total++; if (o !== e) begin bad++; $display("FAIL unknown_op: got %h want %h", o, e); end
  endtask

  task automatic test_ecall_halt();
    stat_t o, e;
    run_instr(OP_EC, 1'b0, 1'b0, 0, 0, o);
    e = model(OP_EC, 1'b0, 1'b0, 0, 0);
    total++; if (o !== e) begin bad++; $display("FAIL ecall_nohalt: got %h want %h", o, e); end
    run_instr(OP_EC, 1'b0, 1'b1, 0, 0, o);
    e = model(OP_EC, 1'b0, 1'b1, 0, 0);
    total++; if (o !== e) begin bad++; $display("FAIL ecall_halt: got %h want %h", o, e); end
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if ({ctrl, halted, mem_timeout} !== {14'd0, 1'b1, 1'b0}) begin
        bad++; $display("FAIL halt_hold_%0d: got %h want %h", i, {ctrl, halted, mem_timeout}, {14'd0, 2'b10});
      end
    end
    do_reset();
    #1;
    total++;
    if ({mem_read, halted} !== 2'b10) begin
      bad++; $display("FAIL halt_restart: got rd/halted=%b want 10", {mem_read, halted});
    end
  endtask

  task automatic test_timeout();
    stat_t o, e;
    run_instr(OP_ST, 1'b0, 1'b0, 0, MAXW + 1, o);
    e = model(OP_ST, 1'b0, 1'b0, 0, MAXW + 1);
    total++; if (o !== e) begin bad++; $display("FAIL sw_timeout: got %h want %h", o, e); end
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if ({mem_write, mem_timeout, halted} !== 3'b011) begin
        bad++; $display("FAIL post_timeout_%0d: got wr/tmo/halt=%b want 011", i, {mem_write, mem_timeout, halted});
      end
    end
    do_reset();
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", mem_timeout); end
  endtask

  task automatic test_boundary();
    stat_t o, e;
    run_instr(OP_ST, 1'b0, 1'b0, 0, MAXW, o);
    e = model(OP_ST, 1'b0, 1'b0, 0, MAXW);
    total++; if (o !== e) begin bad++; $display("FAIL mem_boundary: got %h want %h", o, e); end
    run_instr(OP_I, 1'b0, 1'b0, MAXW, 0, o);
    e = model(OP_I, 1'b0, 1'b0, MAXW, 0);
    total++; if (o !== e) begin bad++; $display("FAIL if_boundary: got %h want %h", o, e); end
    run_instr(OP_R, 1'b0, 1'b0, MAXW + 1, 0, o);
    e = model(OP_R, 1'b0, 1'b0, MAXW + 1, 0);
    total++; if (o !== e) begin bad++; $display("FAIL if_timeout: got %h want %h", o, e); end
    do_reset();
  endtask

  task automatic test_reset_abort();
    stat_t o, e;
    opcode = OP_LD;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if ({i_or_d, mem_read, mem_write} !== 3'b110) begin
      bad++; $display("FAIL abort_in_mem: got %b want 110", {i_or_d, mem_read, mem_write});
    end
    reset = 1'b0;
    #1;
    total++; if (ctrl !== 14'd0) begin bad++; $display("FAIL abort_ctrl: got %h want 0", ctrl); end
    @(negedge clk); #1;
    total++; if (ctrl !== 14'd0) begin bad++; $display("FAIL abort_hold: got %h want 0", ctrl); end
    reset = 1'b1;
    #1;
    total++;
    if ({mem_read, i_or_d} !== 2'b10) begin
      bad++; $display("FAIL abort_refetch: got %b want 10", {mem_read, i_or_d});
    end
    run_instr(OP_R, 1'b0, 1'b0, 1, 0, o);
    e = model(OP_R, 1'b0, 1'b0, 1, 0);
    total++; if (o !== e) begin bad++; $display("FAIL abort_next: got %h want %h", o, e); end
  endtask

  task automatic test_back_to_back();
    stat_t o, e;
    logic [6:0] ops [9];
    logic [6:0] op;
    logic bc, hr;
    int wif, wmem;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_EC, OP_LUI};
    for (int i = 0; i < 60; i++) begin
      op   = ops[$urandom_range(0, 8)];
      bc   = 1'($urandom_range(0, 1));
      hr   = ($urandom_range(0, 3) == 0);
      wif  = ($urandom_range(0, 11) == 0) ? MAXW + 1 : int'($urandom_range(0, 3));
      wmem = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW, MAXW + 1)) : int'($urandom_range(0, 3));
      run_instr(op, bc, hr, wif, wmem, o);
      e = model(op, bc, hr, wif, wmem);
      total++;
      if (o !== e) begin
        bad++; $display("FAIL rand_%0d op=%b w=%0d/%0d: got %h want %h", i, op, wif, wmem, o, e);
      end
      if (o.hlt) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_jumps();
    test_ecall_halt();
    test_timeout();
    test_boundary();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
